mc_ctrl: RTL and testbench

- Multi-cycle sequencer for the MIPS datapath (PC/IM, GRF, ALU, DM, writeback mux, register-address mux).
- Replaces single-cycle combinational control: steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives per-state enables.
- Waits on a shared memory-ready handshake for both instruction and data memory.
- Halts on illegal opcodes or memory timeout.

---
 rtl/mc_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS datapath: FETCH/DECODE/EXEC/MEM/WB with memory wait timeout.
// Define MC_CTRL_ICOUNT_EN to add the retired-instruction counter output icount.
module mc_ctrl #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic [1:0] ext_op,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
`ifdef MC_CTRL_ICOUNT_EN
  ,
  output logic [31:0] icount
`endif
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    K_ADDU, K_SUBU, K_JR, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_JAL, K_ILL
  } kind_e;

  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] WCNT_ONE = CW'(1);
  localparam logic [CW-1:0] WCNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] WLIM_M1  = CW'(WAIT_LIMIT - 1);

  function automatic kind_e decode(input logic [5:0] o, input logic [5:0] f);
    kind_e k;
    k = K_ILL;
    case (o)
      6'b000000: begin
        case (f)
          6'b100001: k = K_ADDU;
          6'b100011: k = K_SUBU;
          6'b001000: k = K_JR;
          default:   k = K_ILL;
        endcase
      end
      6'b001101: k = K_ORI;
      6'b100011: k = K_LW;
      6'b101011: k = K_SW;
      6'b000100: k = K_BEQ;
      6'b001111: k = K_LUI;
      6'b000010: k = K_J;
      6'b000011: k = K_JAL;
      default:   k = K_ILL;
    endcase
    return k;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;
  kind_e         kind_s;

  assign kind_s  = decode(op, funct);
  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

  // Next state, wait counter and sticky error flags
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_INIT: begin
        state_d = S_FETCH;
        wcnt_d  = '0;
      end
      S_FETCH, S_MEM: begin
        if (mem_ready) begin
          wcnt_d = '0;
          if (state_q == S_FETCH) begin
            state_d = S_DECODE;
          end else if (kind_s == K_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end else if ((WAIT_LIMIT > 0) && (wcnt_q == WLIM_M1)) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else if (wcnt_q != WCNT_MAX) begin
          wcnt_d = wcnt_q + WCNT_ONE;
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      S_DECODE: begin
        if (kind_s == K_ILL) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wcnt_d = '0;
        case (kind_s)
          K_ADDU, K_SUBU, K_ORI, K_LUI: state_d = S_WB;
          K_LW, K_SW:                   state_d = S_MEM;
          K_BEQ, K_J, K_JAL, K_JR:      state_d = S_FETCH;
          default:                      state_d = S_HALT;
        endcase
      end
      S_WB: begin
        state_d = S_FETCH;
        wcnt_d  = '0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INIT;
      wcnt_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Enables react to mem_ready and zero within the cycle, so they are decoded from the registered state
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    npc_sel  = 2'b00;
    reg_we   = 1'b0;
    reg_dst  = 2'b00;
    wd_sel   = 2'b00;
    alu_src  = 1'b0;
    alu_op   = 2'b00;
    ext_op   = 2'b00;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end else begin
          ir_we = 1'b0;
        end
      end
      S_EXEC: begin
        case (kind_s)
          K_SUBU: alu_op = 2'b01;
          K_ORI: begin
            alu_src = 1'b1;
            alu_op  = 2'b10;
          end
          K_LUI: begin
            alu_src = 1'b1;
            ext_op  = 2'b10;
            alu_op  = 2'b11;
          end
          K_LW, K_SW: begin
            alu_src = 1'b1;
            ext_op  = 2'b01;
          end
          K_BEQ: begin
            alu_op  = 2'b01;
            npc_sel = 2'b01;
            pc_we   = zero;
          end
          K_J: begin
            pc_we   = 1'b1;
            npc_sel = 2'b10;
          end
          K_JAL: begin
            pc_we   = 1'b1;
            npc_sel = 2'b10;
            reg_we  = 1'b1;
            reg_dst = 2'b10;
            wd_sel  = 2'b10;
          end
          K_JR: begin
            pc_we   = 1'b1;
            npc_sel = 2'b11;
          end
          default: alu_op = 2'b00;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (kind_s == K_SW);
        alu_src  = 1'b1;
        ext_op   = 2'b01;
      end
      S_WB: begin
        reg_we = 1'b1;
        case (kind_s)
          K_ADDU, K_SUBU: reg_dst = 2'b01;
          K_LW:           wd_sel  = 2'b01;
          default:        reg_dst = 2'b00;
        endcase
      end
      default: imem_req = 1'b0;
    endcase
  end

`ifdef MC_CTRL_ICOUNT_EN
  logic [31:0] icount_q;
  logic        retire_s;

  assign retire_s = (state_d == S_FETCH) && (state_q inside {S_EXEC, S_MEM, S_WB});
  assign icount   = icount_q;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icount_q <= 32'd0;
    end else if (retire_s) begin
      icount_q <= icount_q + 32'd1;
    end else begin
      icount_q <= icount_q;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: walks each instruction class, memory waits, timeout, illegal halt, reset.
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, alu_src, illegal, timeout;
  logic [1:0] npc_sel, reg_dst, wd_sel, alu_op, ext_op;
  logic [2:0] state;
  logic [16:0] ctl_s;
`ifdef MC_CTRL_ICOUNT_EN
  logic [31:0] icount;
`endif

  int vectors = 0;
  int errs    = 0;

  mc_ctrl #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .npc_sel(npc_sel), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src),
    .alu_op(alu_op), .ext_op(ext_op), .state(state), .illegal(illegal), .timeout(timeout)
`ifdef MC_CTRL_ICOUNT_EN
    , .icount(icount)
`endif
  );

  always #5 clk = ~clk;

  assign ctl_s = {imem_req, dmem_req, dmem_we, ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel,
                  alu_src, alu_op, ext_op};

  function automatic logic [16:0] e(input logic imem, input logic dreq, input logic dwe,
                                    input logic irwe, input logic pcwe, input logic [1:0] npc,
                                    input logic rwe, input logic [1:0] rdst, input logic [1:0] wds,
                                    input logic asrc, input logic [1:0] aop, input logic [1:0] ext);
    return {imem, dreq, dwe, irwe, pcwe, npc, rwe, rdst, wds, asrc, aop, ext};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [2:0] st, input logic [16:0] c);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".ctl"}, 32'(ctl_s), 32'(c));
  endtask

  logic [16:0] c_fr, c_fw, c_ls_e, c_sw_m, c_lw_m;

  // Check FETCH (ready) and DECODE, leaving the bench at the start of the following cycle
  task automatic fd(input string tag, input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    mem_ready = 1'b1;
    expect_st({tag, ".F"}, 3'd1, c_fr);
    cyc();
    expect_st({tag, ".D"}, 3'd2, 17'd0);
    cyc();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    c_fr   = e(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00);
    c_fw   = e(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00);
    c_ls_e = e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01);
    c_sw_m = e(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01);
    c_lw_m = e(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01);

    reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) cyc();
    expect_st("rst", 3'd0, 17'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);
    reset = 1'b1;
    expect_st("init", 3'd0, 17'd0);
    cyc();
`ifdef MC_CTRL_ICOUNT_EN
    chk("icount0", icount, 32'd0);
`endif

    // addu: FETCH, DECODE, EXEC, WB, FETCH
    fd("addu", 6'b000000, 6'b100001);
    expect_st("addu.E", 3'd3, 17'd0);
    cyc();
    expect_st("addu.W", 3'd5, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00));
    cyc();
`ifdef MC_CTRL_ICOUNT_EN
    chk("icount1", icount, 32'd1);
`endif

    fd("sw", 6'b101011, 6'b000000);
    expect_st("sw.E", 3'd3, c_ls_e);
    cyc();
    expect_st("sw.M", 3'd4, c_sw_m);
    cyc();
`ifdef MC_CTRL_ICOUNT_EN
    chk("icount2", icount, 32'd2);
`endif

    // lw with three not-ready cycles in MEM
    fd("lw", 6'b100011, 6'b000000);
    expect_st("lw.E", 3'd3, c_ls_e);
    cyc();
    mem_ready = 1'b0;
    expect_st("lw.M1", 3'd4, c_lw_m);
    for (int i = 0; i < 2; i++) begin
      cyc();
      expect_st("lw.Mw", 3'd4, c_lw_m);
    end
    cyc();
    mem_ready = 1'b1;
    expect_st("lw.M4", 3'd4, c_lw_m);
    cyc();
    expect_st("lw.W", 3'd5, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00));
    chk("lw.timeout", 32'(timeout), 32'd0);
    cyc();

    fd("beq1", 6'b000100, 6'b000000);
    zero = 1'b1;
    expect_st("beq1.E", 3'd3, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00));
    cyc();
    fd("beq0", 6'b000100, 6'b000000);
    zero = 1'b0;
    expect_st("beq0.E", 3'd3, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00));
    cyc();

    fd("jal", 6'b000011, 6'b000000);
    expect_st("jal.E", 3'd3, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10, 1'b0, 2'b00, 2'b00));
    cyc();
    fd("jr", 6'b000000, 6'b001000);
    expect_st("jr.E", 3'd3, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00));
    cyc();
    fd("ori", 6'b001101, 6'b000000);
    expect_st("ori.E", 3'd3, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00));
    cyc();
    expect_st("ori.W", 3'd5, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00));
    cyc();
    fd("lui", 6'b001111, 6'b000000);
    expect_st("lui.E", 3'd3, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 2'b11, 2'b10));
    cyc();
    expect_st("lui.W", 3'd5, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00));
    cyc();
    fd("subu", 6'b000000, 6'b100011);
    expect_st("subu.E", 3'd3, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00));
    cyc();
    expect_st("subu.W", 3'd5, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00));
    cyc();
    fd("j", 6'b000010, 6'b000000);
    expect_st("j.E", 3'd3, e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00));
    cyc();

    // Illegal opcode halts with no enables
    fd("ill", 6'b111111, 6'b000000);
    expect_st("ill.H", 3'd6, 17'd0);
    chk("ill.flag", 32'(illegal), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      expect_st("ill.Hold", 3'd6, 17'd0);
    end

    reset = 1'b0;
    expect_st("rst2", 3'd0, 17'd0);
    chk("rst2.illegal", 32'(illegal), 32'd0);
    reset = 1'b1;
    op = 6'b000000; funct = 6'b100001; mem_ready = 1'b0;
    cyc();
    // Ready arriving on the last allowed wait cycle beats the timeout
    for (int i = 0; i < 14; i++) begin
      expect_st("wait14.F", 3'd1, c_fw);
      cyc();
    end
    mem_ready = 1'b1;
    expect_st("wait15.F", 3'd1, c_fr);
    cyc();
    expect_st("wait.D", 3'd2, 17'd0);
    chk("wait.timeout", 32'(timeout), 32'd0);
    cyc();
    cyc();
    mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 15; i++) begin
      expect_st("to.F", 3'd1, c_fw);
      chk("to.flag0", 32'(timeout), 32'd0);
      cyc();
    end
    expect_st("to.H", 3'd6, 17'd0);
    chk("to.flag1", 32'(timeout), 32'd1);

    reset = 1'b0;
    expect_st("rst3", 3'd0, 17'd0);
    chk("rst3.timeout", 32'(timeout), 32'd0);
    reset = 1'b1;
    mem_ready = 1'b1;
    cyc();
    fd("lw2", 6'b100011, 6'b000000);
    cyc();
    mem_ready = 1'b0;
    expect_st("lw2.M", 3'd4, c_lw_m);
    reset = 1'b0;
    expect_st("midrst", 3'd0, 17'd0);
    chk("midrst.illegal", 32'(illegal), 32'd0);
    chk("midrst.timeout", 32'(timeout), 32'd0);
`ifdef MC_CTRL_ICOUNT_EN
    chk("midrst.icount", icount, 32'd0);
`endif
    reset = 1'b1;
    cyc();
    expect_st("post.F", 3'd1, c_fw);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
